pe_sequencer: RTL and testbench

Upstream control and alignment stage for the radix-2 PE. It accepts one 4-sample group per cycle for a selected FFT stage, registers the group, and presents it on `pe_in0..3`. In the same cycle it presents the matching twiddle on `tf` and the trivial-twiddle flag on `bypass_n`. It also tracks the 4-cycle PE pipeline, so it can flag valid PE outputs and signal end-of-stage.

---
 rtl/pe_sequencer.sv | 144 ++++++++++++++
 tb/tb_pe_sequencer.sv | 300 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/pe_sequencer.sv
// pe_sequencer: stage control, group alignment and twiddle ROM feeding the radix-2 PE.
// Optional macro PE_SEQ_BYPASS_EN drives bypass_n low whenever the twiddle index is 0.
`timescale 1ns/1ps
module pe_sequencer #(
  parameter int WIDTH = 32,
  parameter int SHIFT = 16,
  parameter int LOG2N = 10
) (
  input  logic                       Clk,
  input  logic                       Reset_n,
  input  logic                       start,
  input  logic [$clog2(LOG2N)-1:0]   stage,
  input  logic                       in_valid,
  input  logic [WIDTH-1:0]           in0,
  input  logic [WIDTH-1:0]           in1,
  input  logic [WIDTH-1:0]           in2,
  input  logic [WIDTH-1:0]           in3,
  output logic [WIDTH-1:0]           pe_in0,
  output logic [WIDTH-1:0]           pe_in1,
  output logic [WIDTH-1:0]           pe_in2,
  output logic [WIDTH-1:0]           pe_in3,
  output logic [2*WIDTH-1:0]         tf,
  output logic                       bypass_n,
  output logic                       pe_out_valid,
  output logic                       busy,
  output logic                       done,
  output logic                       err
);
  localparam int N    = 1 << LOG2N;
  localparam int HALF = N / 2;
  localparam int GW   = LOG2N - 2;
  localparam int KW   = LOG2N - 1;
  localparam int SW   = $clog2(LOG2N);
  localparam int F    = 60;

  typedef logic signed [127:0] fx_t;
  localparam fx_t PI_FX = 128'sh3243F6A8885A308D;  // pi * 2^60

  // cos/sin by Taylor series in Q60 fixed point, then round-half-up to Q(SHIFT)
  function automatic logic [2*WIDTH-1:0] tw_entry(input int unsigned k);
    fx_t x, x2, c, s, tc, ts, half, rc, rs;
    x  = (PI_FX * fx_t'(k)) >>> (LOG2N - 1);
    x2 = (x * x) >>> F;
    c  = fx_t'(1) <<< F;
    s  = x;
    tc = c;
    ts = x;
    for (int unsigned i = 1; i <= 24; i++) begin
      tc = -(((tc * x2) >>> F) / fx_t'((2 * i - 1) * (2 * i)));
      ts = -(((ts * x2) >>> F) / fx_t'((2 * i) * (2 * i + 1)));
      c  = c + tc;
      s  = s + ts;
    end
    half = fx_t'(1) <<< (F - SHIFT - 1);
    rc   = (c + half) >>> (F - SHIFT);
    rs   = (s + half) >>> (F - SHIFT);
    return {WIDTH'(rc), WIDTH'(rs)};
  endfunction

  logic [2*WIDTH-1:0] rom [HALF];
  for (genvar gk = 0; gk < HALF; gk++) begin : g_rom
    localparam logic [2*WIDTH-1:0] ENTRY = tw_entry(gk);
    assign rom[gk] = ENTRY;
  end

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DRAIN, S_DONE} state_t;

  state_t          state;
  logic [GW-1:0]   g;
  logic [SW-1:0]   s_q;
  logic [KW-1:0]   k_idx;
  logic            strobe;
  logic [4:0]      vsr;

  always_comb k_idx = KW'(g) << s_q;

  // strobe is the sequencer register stage; vsr covers the four PE stages
  assign pe_out_valid = vsr[4];

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      state    <= S_IDLE;
      g        <= '0;
      s_q      <= '0;
      strobe   <= 1'b0;
      vsr      <= '0;
      pe_in0   <= '0;
      pe_in1   <= '0;
      pe_in2   <= '0;
      pe_in3   <= '0;
      tf       <= '0;
      bypass_n <= 1'b1;
      busy     <= 1'b0;
      done     <= 1'b0;
      err      <= 1'b0;
    end else begin
      done   <= 1'b0;
      err    <= 1'b0;
      strobe <= 1'b0;
      vsr    <= {vsr[3:0], strobe};
      case (state)
        S_IDLE: begin
          if (start) begin
            if (int'(stage) < LOG2N) begin
              s_q   <= stage;
              g     <= '0;
              busy  <= 1'b1;
              state <= S_RUN;
            end else begin
              err <= 1'b1;
            end
          end
        end
        S_RUN: begin
          if (in_valid) begin
            pe_in0 <= in0;
            pe_in1 <= in1;
            pe_in2 <= in2;
            pe_in3 <= in3;
            tf     <= rom[k_idx];
`ifdef PE_SEQ_BYPASS_EN
            bypass_n <= (k_idx != '0);
`else
            bypass_n <= 1'b1;
`endif
            g      <= g + 1'b1;
            strobe <= 1'b1;
            if (g == '1) state <= S_DRAIN;
          end
        end
        // the last group is the only one left in flight once it reaches vsr[4]
        S_DRAIN: begin
          if (vsr[4] && !strobe && vsr[3:0] == '0) begin
            busy  <= 1'b0;
            done  <= 1'b1;
            state <= S_DONE;
          end
        end
        S_DONE: state <= S_IDLE;
        default: state <= S_IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_pe_sequencer.sv
// Randomized self-checking bench for pe_sequencer against a transaction-level reference model.
`timescale 1ns/1ps
module tb_pe_sequencer;
  localparam int W  = 32;
  localparam int SH = 16;
  localparam int L  = 4;
  localparam int N  = 1 << L;
  localparam int NG = N / 4;

  logic          Clk = 1'b0;
  logic          Reset_n = 1'b1;
  logic          start, in_valid;
  logic [1:0]    stage;
  logic [W-1:0]  in0, in1, in2, in3;
  logic [W-1:0]  pe_in0, pe_in1, pe_in2, pe_in3;
  logic [2*W-1:0] tf;
  logic          bypass_n, pe_out_valid, busy, done, err;

  logic          start5, in_valid5;
  logic [2:0]    stage5;
  logic [W-1:0]  e5_pe0, e5_pe1, e5_pe2, e5_pe3;
  logic [2*W-1:0] e5_tf;
  logic          e5_byp, e5_pov, e5_busy, e5_done, e5_err;

  always #5 Clk = ~Clk;

  pe_sequencer #(.WIDTH(W), .SHIFT(SH), .LOG2N(L)) dut (
    .Clk(Clk), .Reset_n(Reset_n), .start(start), .stage(stage), .in_valid(in_valid),
    .in0(in0), .in1(in1), .in2(in2), .in3(in3),
    .pe_in0(pe_in0), .pe_in1(pe_in1), .pe_in2(pe_in2), .pe_in3(pe_in3),
    .tf(tf), .bypass_n(bypass_n), .pe_out_valid(pe_out_valid),
    .busy(busy), .done(done), .err(err)
  );

  // second instance with 3-bit stage so out-of-range stage values are expressible
  pe_sequencer #(.WIDTH(W), .SHIFT(SH), .LOG2N(5)) dut_e (
    .Clk(Clk), .Reset_n(Reset_n), .start(start5), .stage(stage5), .in_valid(in_valid5),
    .in0(in0), .in1(in1), .in2(in2), .in3(in3),
    .pe_in0(e5_pe0), .pe_in1(e5_pe1), .pe_in2(e5_pe2), .pe_in3(e5_pe3),
    .tf(e5_tf), .bypass_n(e5_byp), .pe_out_valid(e5_pov),
    .busy(e5_busy), .done(e5_done), .err(e5_err)
  );

  int n_checks = 0;
  int n_fail = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  function automatic int rnd(input real x);
    return (x >= 0.0) ? $rtoi(x + 0.5) : -$rtoi(0.5 - x);
  endfunction

  function automatic logic [63:0] tw(input int k);
    real a;
    int re, im;
    a  = 2.0 * 3.14159265358979323846 * real'(k) / real'(N);
    re = rnd($cos(a) * real'(1 << SH));
    im = rnd($sin(a) * real'(1 << SH));
    return {re, im};
  endfunction

  // reference model: expected outputs after each rising edge
  logic [W-1:0]  m_pe [4];
  logic [63:0]   m_tf;
  logic          m_byp, m_pov, m_busy, m_done, m_err;
  bit            m_active, m_run;
  bit            ahist [5];
  int            m_grp, m_s, ed = 0, done_edge, last_acc_edge;

  task automatic model_reset();
    m_pe = '{default: '0};
    m_tf = '0;
    m_byp = 1'b1;
    {m_pov, m_busy, m_done, m_err} = '0;
    m_active = 0;
    m_run = 0;
    ahist = '{default: 0};
    done_edge = -100;
  endtask

  task automatic model_edge();
    bit acc;
    int k;
    ed++;
    if (!Reset_n) begin
      model_reset();
      return;
    end
    acc = 0;
    m_done = 1'b0;
    m_err = 1'b0;
    if (!m_active) begin
      if (start) begin
        if (int'(stage) < L) begin
          m_active = 1; m_run = 1; m_grp = 0; m_s = int'(stage); m_busy = 1'b1;
        end else m_err = 1'b1;
      end
    end else if (m_run) begin
      if (in_valid) begin
        acc = 1;
        k = (m_grp << m_s) % (N / 2);
        m_pe = '{in0, in1, in2, in3};
        m_tf = tw(k);
`ifdef PE_SEQ_BYPASS_EN
        m_byp = (k != 0);
`else
        m_byp = 1'b1;
`endif
        m_grp++;
        last_acc_edge = ed;
        if (m_grp == NG) begin
          m_run = 0;
          done_edge = ed + 6;
        end
      end
    end else if (ed == done_edge) begin
      m_done = 1'b1;
      m_busy = 1'b0;
    end else if (ed == done_edge + 1) begin
      m_active = 0;
    end
    m_pov = ahist[4];
    for (int i = 4; i > 0; i--) ahist[i] = ahist[i-1];
    ahist[0] = acc;
  endtask

  task automatic cycle();
    @(posedge Clk);
    model_edge();
    @(negedge Clk);
    check("pe_in0", pe_in0, m_pe[0]);
    check("pe_in1", pe_in1, m_pe[1]);
    check("pe_in2", pe_in2, m_pe[2]);
    check("pe_in3", pe_in3, m_pe[3]);
    check("tf", tf, m_tf);
    check("bypass_n", bypass_n, m_byp);
    check("pe_out_valid", pe_out_valid, m_pov);
    check("busy", busy, m_busy);
    check("done", done, m_done);
    check("err", err, m_err);
  endtask

  task automatic check_reset_vals();
    check("rst_pe_in0", pe_in0, 0);
    check("rst_pe_in3", pe_in3, 0);
    check("rst_tf", tf, 0);
    check("rst_bypass_n", bypass_n, 1);
    check("rst_pe_out_valid", pe_out_valid, 0);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_err", err, 0);
    check("rst_e5_busy", e5_busy, 0);
    check("rst_e5_bypass_n", e5_byp, 1);
  endtask

  task automatic rand_data();
    in0 = $urandom; in1 = $urandom; in2 = $urandom; in3 = $urandom;
  endtask

  task automatic wait_idle();
    int g = 0;
    while (m_active && g < 60) begin
      cycle();
      g++;
    end
  endtask

  task automatic run_stage(input int s, input int p, input bit spur);
    int g = 0;
    start = 1'b1; stage = 2'(s); in_valid = 1'($urandom_range(1)); rand_data();
    cycle();
    start = 1'b0;
    while (m_active && g < 300) begin
      in_valid = ($urandom_range(99) < p);
      rand_data();
      start = spur && ($urandom_range(5) == 0);
      stage = 2'($urandom_range(3));
      cycle();
      g++;
    end
    start = 1'b0; in_valid = 1'b0;
  endtask

  logic [63:0] tf_tab [4] = '{64'h00010000_00000000, 64'h0000B505_0000B505,
                             64'h00000000_00010000, 64'hFFFF4AFB_0000B505};
`ifdef PE_SEQ_BYPASS_EN
  logic byp_tab [4] = '{1'b0, 1'b1, 1'b1, 1'b1};
`else
  logic byp_tab [4] = '{1'b1, 1'b1, 1'b1, 1'b1};
`endif
  logic gap_tab [6] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1};

  initial begin
    int done_seen, pov_count;
    start = 0; stage = '0; in_valid = 0; in0 = '0; in1 = '0; in2 = '0; in3 = '0;
    start5 = 0; stage5 = '0; in_valid5 = 0;
    model_reset();
    #2 Reset_n = 1'b0;
    #1 check_reset_vals();
    repeat (2) cycle();
    Reset_n = 1'b1;
    cycle();

    // directed: s=1, four back-to-back groups
    start = 1'b1; stage = 2'd1;
    cycle();
    start = 1'b0;
    for (int j = 0; j < 4; j++) begin
      in_valid = 1'b1; rand_data();
      cycle();
      check("tf_table", tf, tf_tab[j]);
      check("bypass_table", bypass_n, byp_tab[j]);
    end
    in_valid = 1'b0;
    wait_idle();

    // gapped groups: outputs hold, pe_out_valid follows in_valid by 5, done 6 after last accept
    start = 1'b1; stage = 2'd2;
    cycle();
    start = 1'b0;
    pov_count = 0;
    done_seen = -1;
    for (int j = 0; j < 6; j++) begin
      in_valid = gap_tab[j]; rand_data();
      cycle();
      if (pe_out_valid === 1'b1) pov_count++;
    end
    in_valid = 1'b0; rand_data();
    for (int j = 0; j < 12 && m_active; j++) begin
      cycle();
      if (pe_out_valid === 1'b1) pov_count++;
      if (done === 1'b1) done_seen = ed;
    end
    check("gap_pov_count", 64'(pov_count), 4);
    check("gap_done_latency", 64'(done_seen - last_acc_edge), 6);

    // stage range on the LOG2N=5 instance; start outside IDLE is ignored
    start5 = 1'b1; stage5 = 3'd5;
    cycle();
    check("e5_err_stage5", e5_err, 1);
    check("e5_busy_after_err", e5_busy, 0);
    stage5 = 3'd7;
    cycle();
    check("e5_err_stage7", e5_err, 1);
    start5 = 1'b0;
    cycle();
    check("e5_err_clear", e5_err, 0);
    check("e5_idle_busy", e5_busy, 0);
    check("e5_ignore_in_valid", e5_pe0, 0);
    start5 = 1'b1; stage5 = 3'd4;
    cycle();
    check("e5_accept_stage4", e5_busy, 1);
    check("e5_no_err_stage4", e5_err, 0);
    stage5 = 3'd6;
    cycle();
    check("e5_start_in_run_no_err", e5_err, 0);
    check("e5_still_busy", e5_busy, 1);
    start5 = 1'b0;

    // reset mid-RUN after two groups, with a spurious start on the second
    start = 1'b1; stage = 2'd0;
    cycle();
    start = 1'b0;
    in_valid = 1'b1; rand_data();
    cycle();
    start = 1'b1; stage = 2'd3; rand_data();
    cycle();
    start = 1'b0; in_valid = 1'b0;
    #2 Reset_n = 1'b0;
    #1 check_reset_vals();
    cycle();
    Reset_n = 1'b1;
    run_stage(1, 100, 0);

    // randomized stages: random s, valid density, spurious starts and idle-time in_valid
    for (int r = 0; r < 12; r++) begin
      run_stage($urandom_range(L - 1), $urandom_range(30, 100), 1'b1);
      repeat ($urandom_range(0, 3)) begin
        in_valid = 1'($urandom_range(1)); rand_data();
        cycle();
      end
      in_valid = 1'b0;
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not reach the end (t=%0t)", $time);
    $fatal(1);
  end
endmodule
